// File: rtl/enc_pkg.sv
// Shared definitions for the request encoder/arbiter: mode encodings and
// the index-width helper that keeps a 1-bit index legal for tiny N.
package enc_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational pick: lowest set request at or after the search start, found by
// searching a doubled copy of req so the wrap-around needs no second pass.
module rr_pick
    import enc_pkg::*;
#(
    parameter int N    = 4,
    parameter int IDXW = clog2_min1(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    input  logic            rr_mode,
    output logic [IDXW-1:0] idx,
    output logic            any,
    output logic            multi
);

    logic [2*N-1:0] w_dbl;
    logic [2*N-1:0] w_mask;
    logic [2*N-1:0] w_masked;
    int             w_start;

    // Fixed mode is simply a round-robin search that always starts at 0.
    always_comb begin
        w_start  = (rr_mode == MODE_RR) ? int'(ptr) : 0;
        w_dbl    = {req, req};
        w_mask   = '0;
        for (int i = 0; i < 2*N; i++) begin
            w_mask[i] = (i >= w_start) && (i < w_start + N);
        end
        w_masked = w_dbl & w_mask;
        idx      = '0;
        for (int i = 2*N-1; i >= 0; i--) begin
            if (w_masked[i]) begin
                idx = (i >= N) ? IDXW'(i - N) : IDXW'(i);
            end
        end
    end

    assign any   = |req;
    assign multi = ($countones(req) > 1);

endmodule

// File: rtl/req_encoder_arb.sv
// N-way request encoder with fixed-priority or round-robin selection and a
// registered, stallable valid/ready output.
module req_encoder_arb
    import enc_pkg::*;
#(
    parameter  int N    = 4,
    localparam int IDXW = clog2_min1(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            rr_mode,
    input  logic            flush,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [IDXW-1:0] out_idx,
    output logic            out_multi
);

    logic            r_valid;
    logic [IDXW-1:0] r_idx;
    logic            r_multi;
    logic [IDXW-1:0] r_ptr;

    logic [IDXW-1:0] w_idx;
    logic            w_any;
    logic            w_multi;
    logic            w_load;

    rr_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .req     (req),
        .ptr     (r_ptr),
        .rr_mode (rr_mode),
        .idx     (w_idx),
        .any     (w_any),
        .multi   (w_multi)
    );

    assign w_load = (!r_valid || out_ready) && w_any && !flush;

    // Flush outranks everything; a non-loading accepted cycle means req is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_multi <= 1'b0;
            r_ptr   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_ptr   <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_idx   <= w_idx;
            r_multi <= w_multi;
            if (rr_mode == MODE_RR) begin
                r_ptr <= (w_idx == IDXW'(N - 1)) ? '0 : w_idx + 1'b1;
            end
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_idx   = r_idx;
    assign out_multi = r_multi;

endmodule
